// File: rtl/csr_jobq_pkg.sv
// csr_jobq_pkg: shared constants for the csr_jobq CSR block.
//   - CSR byte addresses (12-bit wide; narrower buses are zero-extended)
//   - CTRL / STATUS / QSTAT bit indices
//   - job descriptor layout: 8 fields x 32 bits, M in the lowest field
//   - reset constants (1.0f for the scale registers, DEAD_BEEF for unmapped reads)
package csr_jobq_pkg;

  localparam logic [11:0] A_CTRL       = 12'h000;
  localparam logic [11:0] A_SHADOW0    = 12'h004;
  localparam logic [11:0] A_QSTAT      = 12'h024;
  localparam logic [11:0] A_STATUS     = 12'h028;
  localparam logic [11:0] A_IRQ_MASK   = 12'h02C;
  localparam logic [11:0] A_DONE_CNT   = 12'h030;
  localparam logic [11:0] A_PERF_BUSY  = 12'h034;
  localparam logic [11:0] A_PERF_STALL = 12'h038;

  localparam int unsigned CTRL_DOORBELL = 0;
  localparam int unsigned CTRL_ABORT    = 1;
  localparam int unsigned CTRL_IRQ_EN   = 2;

  localparam int unsigned ST_BUSY = 0;
  localparam int unsigned ST_DONE = 1;
  localparam int unsigned ST_OVF  = 8;
  localparam int unsigned ST_ILL  = 9;
  localparam int unsigned ST_CRC  = 10;

  localparam int unsigned QS_FULL  = 16;
  localparam int unsigned QS_EMPTY = 17;

  // Descriptor field indices; field i lives at desc[32*i +: 32] and at
  // CSR address A_SHADOW0 + 4*i.
  localparam int unsigned DESC_M      = 0;
  localparam int unsigned DESC_N      = 1;
  localparam int unsigned DESC_K      = 2;
  localparam int unsigned DESC_TM     = 3;
  localparam int unsigned DESC_TN     = 4;
  localparam int unsigned DESC_TK     = 5;
  localparam int unsigned DESC_SA     = 6;
  localparam int unsigned DESC_SW     = 7;
  localparam int unsigned DESC_FIELDS = 8;
  localparam int unsigned FIELD_W     = 32;
  localparam int unsigned DESC_W      = DESC_FIELDS * FIELD_W;

  localparam logic [31:0] RST_ONE_F    = 32'h3F80_0000;
  localparam logic [31:0] RST_UNMAPPED = 32'hDEAD_BEEF;

  function automatic logic [11:0] shadow_addr(input int unsigned idx);
    return A_SHADOW0 + 12'(idx * 4);
  endfunction

  function automatic logic [31:0] shadow_rst(input int unsigned idx);
    return (idx >= DESC_SA) ? RST_ONE_F : '0;
  endfunction

endpackage

// File: rtl/csr_job_fifo.sv
// csr_job_fifo: first-word fall-through queue of job descriptors.
//   clk, rst (async, active-high)
//   push/din  : write an entry; accepted when not full, or when full and
//               a pop happens in the same cycle
//   pop       : remove the head; ignored when empty
//   flush     : empty the queue; overrides push and pop
//   dout      : head entry (valid while !empty)
//   level, full, empty : occupancy
module csr_job_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 256,
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] dout,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push, do_pop;

  assign full    = (count == LVL_W'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign do_pop  = pop && !empty;
  // When full, a same-cycle pop frees the slot wr_ptr points at (== rd_ptr).
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/csr_jobq.sv
// csr_jobq: accelerator CSR block with a doorbell-fed job queue.
//   Host side : csr_wen/csr_ren/csr_addr/csr_wdata in, csr_rdata/csr_rvalid
//               out (registered, one cycle after csr_ren).
//   Core side : job_valid/job_ready/job_desc FWFT handshake, core_busy and
//               core_done_pulse status inputs, abort_pulse out.
//   Misc      : rx_crc_error sticky input, irq registered level output.
//   Optional  : define CSR_PERF_CNT_EN to add PERF_BUSY (0x34) and
//               PERF_STALL (0x38) saturating counters.
module csr_jobq
  import csr_jobq_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned JOBQ_DEPTH = 4,
  parameter int unsigned LVL_W      = $clog2(JOBQ_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              csr_wen,
  input  logic              csr_ren,
  input  logic [ADDR_W-1:0] csr_addr,
  input  logic [31:0]       csr_wdata,
  output logic [31:0]       csr_rdata,
  output logic              csr_rvalid,
  input  logic              core_busy,
  input  logic              core_done_pulse,
  input  logic              rx_crc_error,
  output logic              job_valid,
  input  logic              job_ready,
  output logic [255:0]      job_desc,
  output logic              abort_pulse,
  output logic              irq
);
  logic [11:0]        addr;
  logic [31:0]        shadow [DESC_FIELDS];
  logic [DESC_W-1:0]  shadow_flat;
  logic               irq_en, st_done, st_ovf, st_ill, st_crc;
  logic [10:1]        irq_mask;
  logic [31:0]        done_cnt;
  logic [31:0]        status, qstat, rd_mux;
  logic               wr_ctrl, wr_status, wr_mask, wr_cnt;
  logic               abort_req, doorbell, illegal, push_req, pop, overflow;
  logic [LVL_W-1:0]   q_level;
  logic               q_full, q_empty;

  assign addr      = 12'(csr_addr);
  assign wr_ctrl   = csr_wen && (addr == A_CTRL);
  assign wr_status = csr_wen && (addr == A_STATUS);
  assign wr_mask   = csr_wen && (addr == A_IRQ_MASK);
  assign wr_cnt    = csr_wen && (addr == A_DONE_CNT);

  // Abort in the same write as a doorbell suppresses the doorbell entirely.
  assign abort_req = wr_ctrl && csr_wdata[CTRL_ABORT];
  assign doorbell  = wr_ctrl && csr_wdata[CTRL_DOORBELL] && !csr_wdata[CTRL_ABORT];
  assign illegal   = doorbell && ((shadow[DESC_TM] == '0) || (shadow[DESC_TN] == '0) ||
                                  (shadow[DESC_TK] == '0));
  assign push_req  = doorbell && !illegal;
  assign pop       = job_valid && job_ready;
  assign overflow  = push_req && q_full && !pop;
  assign job_valid = !q_empty;

  always_comb begin
    shadow_flat = '0;
    for (int unsigned i = 0; i < DESC_FIELDS; i++) shadow_flat[i*FIELD_W +: FIELD_W] = shadow[i];
  end

  csr_job_fifo #(.DEPTH(JOBQ_DEPTH), .WIDTH(DESC_W), .LVL_W(LVL_W)) u_fifo (
    .clk(clk), .rst(rst), .push(push_req), .din(shadow_flat), .pop(pop),
    .flush(abort_req), .dout(job_desc), .level(q_level), .full(q_full), .empty(q_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DESC_FIELDS; i++) shadow[i] <= shadow_rst(i);
    end else if (csr_wen) begin
      for (int unsigned i = 0; i < DESC_FIELDS; i++)
        if (addr == shadow_addr(i)) shadow[i] <= csr_wdata;
    end
  end

  // Sticky bits: a set event in the same cycle as its W1C wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en      <= 1'b0;
      st_done     <= 1'b0;
      st_ovf      <= 1'b0;
      st_ill      <= 1'b0;
      st_crc      <= 1'b0;
      irq_mask    <= '0;
      done_cnt    <= '0;
      abort_pulse <= 1'b0;
      irq         <= 1'b0;
      csr_rdata   <= '0;
      csr_rvalid  <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en   <= csr_wdata[CTRL_IRQ_EN];
      if (wr_mask) irq_mask <= csr_wdata[10:1];
      st_done <= core_done_pulse | (st_done & ~(wr_status & csr_wdata[ST_DONE]));
      st_ovf  <= overflow        | (st_ovf  & ~(wr_status & csr_wdata[ST_OVF]));
      st_ill  <= illegal         | (st_ill  & ~(wr_status & csr_wdata[ST_ILL]));
      st_crc  <= rx_crc_error    | (st_crc  & ~(wr_status & csr_wdata[ST_CRC]));
      if (wr_cnt)                                 done_cnt <= core_done_pulse ? 32'd1 : '0;
      else if (core_done_pulse && done_cnt != '1) done_cnt <= done_cnt + 1'b1;
      abort_pulse <= abort_req;
      irq         <= irq_en && |(status[10:1] & irq_mask);
      csr_rvalid  <= csr_ren;
      if (csr_ren) csr_rdata <= rd_mux;
    end
  end

`ifdef CSR_PERF_CNT_EN
  logic [31:0] perf_busy, perf_stall;
  logic        wr_perf;
  assign wr_perf = csr_wen && ((addr == A_PERF_BUSY) || (addr == A_PERF_STALL));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy  <= '0;
      perf_stall <= '0;
    end else if (wr_perf) begin
      perf_busy  <= '0;
      perf_stall <= '0;
    end else begin
      if (core_busy && perf_busy != '1) perf_busy <= perf_busy + 1'b1;
      if (job_valid && !job_ready && perf_stall != '1) perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

  always_comb begin
    status           = '0;
    status[ST_BUSY]  = core_busy;
    status[ST_DONE]  = st_done;
    status[ST_OVF]   = st_ovf;
    status[ST_ILL]   = st_ill;
    status[ST_CRC]   = st_crc;
    qstat            = '0;
    qstat[LVL_W-1:0] = q_level;
    qstat[QS_FULL]   = q_full;
    qstat[QS_EMPTY]  = q_empty;
    rd_mux           = RST_UNMAPPED;
    case (addr)
      A_CTRL:       begin rd_mux = '0; rd_mux[CTRL_IRQ_EN] = irq_en; end
      A_QSTAT:      rd_mux = qstat;
      A_STATUS:     rd_mux = status;
      A_IRQ_MASK:   begin rd_mux = '0; rd_mux[10:1] = irq_mask; end
      A_DONE_CNT:   rd_mux = done_cnt;
`ifdef CSR_PERF_CNT_EN
      A_PERF_BUSY:  rd_mux = perf_busy;
      A_PERF_STALL: rd_mux = perf_stall;
`endif
      default: begin
        for (int unsigned i = 0; i < DESC_FIELDS; i++)
          if (addr == shadow_addr(i)) rd_mux = shadow[i];
      end
    endcase
  end

endmodule

// File: tb/tb_csr_jobq.sv
`timescale 1ns/1ps
module tb_csr_jobq;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              csr_wen, csr_ren;
  logic [ADDR_W-1:0] csr_addr;
  logic [31:0]       csr_wdata;
  logic [31:0]       csr_rdata;
  logic              csr_rvalid;
  logic              core_busy, core_done_pulse, rx_crc_error;
  logic              job_valid, job_ready;
  logic [255:0]      job_desc;
  logic              abort_pulse, irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  csr_jobq #(.ADDR_W(ADDR_W), .JOBQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .csr_wen(csr_wen), .csr_ren(csr_ren), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_rvalid(csr_rvalid),
    .core_busy(core_busy), .core_done_pulse(core_done_pulse), .rx_crc_error(rx_crc_error),
    .job_valid(job_valid), .job_ready(job_ready), .job_desc(job_desc),
    .abort_pulse(abort_pulse), .irq(irq)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic csr_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_wen = 1'b1; csr_addr = a; csr_wdata = d;
    @(negedge clk);
    csr_wen = 1'b0;
  endtask

  task automatic csr_read(input logic [ADDR_W-1:0] a, output logic [31:0] d, output logic v);
    @(negedge clk);
    csr_ren = 1'b1; csr_addr = a;
    @(negedge clk);
    csr_ren = 1'b0;
    d = csr_rdata; v = csr_rvalid;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (csr_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want %h", csr_rdata, 32'h0); end
    total++; if ({csr_rvalid, job_valid, abort_pulse, irq} !== 4'b0000) begin bad++;
      $display("FAIL rst_outputs: got %b want %b", {csr_rvalid, job_valid, abort_pulse, irq}, 4'b0000); end
    rst = 1'b0;
    csr_read(8'h1C, d, v);
    total++; if (d !== 32'h3F80_0000 || v !== 1'b1) begin bad++; $display("FAIL rst_sa: got %h/%b want %h/1", d, v, 32'h3F80_0000); end
    csr_read(8'h10, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_tm: got %h want %h", d, 32'h0); end
    csr_read(8'h24, d, v);
    total++; if (d !== 32'h0002_0000) begin bad++; $display("FAIL rst_qstat: got %h want %h", d, 32'h0002_0000); end
    csr_read(8'h30, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_donecnt: got %h want %h", d, 32'h0); end
  endtask

  task automatic test_push_pop();
    logic [31:0] d; logic v;
    csr_write(8'h10, 32'd4);
    csr_write(8'h14, 32'd4);
    csr_write(8'h18, 32'd4);
    csr_write(8'h04, 32'd16);
    job_ready = 1'b0;
    csr_write(8'h00, 32'h1);
    total++; if (job_valid !== 1'b1) begin bad++; $display("FAIL push_valid: got %b want 1", job_valid); end
    total++; if (job_desc[127:96] !== 32'd4) begin bad++; $display("FAIL push_tm: got %h want %h", job_desc[127:96], 32'd4); end
    total++; if (job_desc[31:0] !== 32'd16) begin bad++; $display("FAIL push_m: got %h want %h", job_desc[31:0], 32'd16); end
    total++; if (job_desc[255:224] !== 32'h3F80_0000) begin bad++; $display("FAIL push_sw: got %h want %h", job_desc[255:224], 32'h3F80_0000); end
    csr_read(8'h24, d, v);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL push_level: got %h want %h", d, 32'h1); end
    job_ready = 1'b1;
    @(negedge clk);
    job_ready = 1'b0;
    total++; if (job_valid !== 1'b0) begin bad++; $display("FAIL pop_valid: got %b want 0", job_valid); end
    csr_read(8'h24, d, v);
    total++; if (d !== 32'h0002_0000) begin bad++; $display("FAIL pop_level: got %h want %h", d, 32'h0002_0000); end
  endtask

  task automatic test_illegal();
    logic [31:0] d; logic v;
    csr_write(8'h18, 32'd0);
    csr_write(8'h00, 32'h1);
    total++; if (job_valid !== 1'b0) begin bad++; $display("FAIL ill_nopush: got %b want 0", job_valid); end
    csr_read(8'h28, d, v);
    total++; if (d !== 32'h200) begin bad++; $display("FAIL ill_status: got %h want %h", d, 32'h200); end
    csr_write(8'h28, 32'h200);
    csr_read(8'h28, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL ill_w1c: got %h want %h", d, 32'h0); end
    csr_write(8'h18, 32'd4);
  endtask

  task automatic test_overflow();
    logic [31:0] d; logic v;
    for (int i = 1; i <= 4; i++) begin
      csr_write(8'h04, 32'(i));
      csr_write(8'h00, 32'h1);
    end
    csr_read(8'h24, d, v);
    total++; if (d !== 32'h0001_0004) begin bad++; $display("FAIL ovf_full: got %h want %h", d, 32'h0001_0004); end
    csr_write(8'h04, 32'd9);
    csr_write(8'h00, 32'h1);
    csr_read(8'h28, d, v);
    total++; if (d !== 32'h100) begin bad++; $display("FAIL ovf_err: got %h want %h", d, 32'h100); end
    csr_read(8'h24, d, v);
    total++; if (d !== 32'h0001_0004) begin bad++; $display("FAIL ovf_level: got %h want %h", d, 32'h0001_0004); end
    csr_write(8'h28, 32'h100);
    // full queue, doorbell with a simultaneous pop: accepted, level unchanged
    csr_write(8'h04, 32'd5);
    @(negedge clk);
    csr_wen = 1'b1; csr_addr = 8'h00; csr_wdata = 32'h1; job_ready = 1'b1;
    @(negedge clk);
    csr_wen = 1'b0; job_ready = 1'b0;
    csr_read(8'h28, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL ovf_pop_noerr: got %h want %h", d, 32'h0); end
    csr_read(8'h24, d, v);
    total++; if (d !== 32'h0001_0004) begin bad++; $display("FAIL ovf_pop_level: got %h want %h", d, 32'h0001_0004); end
    job_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (job_desc[31:0] !== 32'(i + 2)) begin bad++;
        $display("FAIL drain_order[%0d]: got %h want %h", i, job_desc[31:0], 32'(i + 2)); end
      @(negedge clk);
    end
    job_ready = 1'b0;
    total++; if (job_valid !== 1'b0) begin bad++; $display("FAIL drain_empty: got %b want 0", job_valid); end
  endtask

  task automatic test_irq();
    logic [31:0] d; logic v;
    csr_write(8'h2C, 32'h2);
    csr_write(8'h00, 32'h4);
    csr_read(8'h00, d, v);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL irq_ctrl_rd: got %h want %h", d, 32'h4); end
    csr_read(8'h2C, d, v);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL irq_mask_rd: got %h want %h", d, 32'h2); end
    @(negedge clk); core_done_pulse = 1'b1;
    @(negedge clk); core_done_pulse = 1'b0;
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_assert: got %b want 1", irq); end
    csr_read(8'h30, d, v);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL irq_donecnt: got %h want %h", d, 32'd1); end
    csr_write(8'h28, 32'h2);
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_deassert: got %b want 0", irq); end
    csr_write(8'h30, 32'h0);
    csr_read(8'h30, d, v);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL cnt_clear: got %h want %h", d, 32'd0); end
    @(negedge clk);
    csr_wen = 1'b1; csr_addr = 8'h30; csr_wdata = 32'h0; core_done_pulse = 1'b1;
    @(negedge clk);
    csr_wen = 1'b0; core_done_pulse = 1'b0;
    csr_read(8'h30, d, v);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL cnt_clear_pulse: got %h want %h", d, 32'd1); end
    csr_write(8'h00, 32'h0);
    csr_write(8'h28, 32'h702);
  endtask

  task automatic test_status_misc();
    logic [31:0] d; logic v;
    core_busy = 1'b1;
    csr_read(8'h28, d, v);
    core_busy = 1'b0;
    total++; if (d !== 32'h1) begin bad++; $display("FAIL busy_bit: got %h want %h", d, 32'h1); end
    @(negedge clk); rx_crc_error = 1'b1;
    @(negedge clk); rx_crc_error = 1'b0;
    csr_read(8'h28, d, v);
    total++; if (d !== 32'h400) begin bad++; $display("FAIL crc_sticky: got %h want %h", d, 32'h400); end
    csr_write(8'h28, 32'h400);
    csr_read(8'h28, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL crc_w1c: got %h want %h", d, 32'h0); end
  endtask

  task automatic test_abort();
    logic [31:0] d; logic v;
    for (int i = 0; i < 3; i++) csr_write(8'h00, 32'h1);
    csr_read(8'h24, d, v);
    total++; if (d !== 32'h3) begin bad++; $display("FAIL abort_pre_level: got %h want %h", d, 32'h3); end
    @(negedge clk);
    csr_wen = 1'b1; csr_addr = 8'h00; csr_wdata = 32'h3;
    @(negedge clk);
    csr_wen = 1'b0;
    total++; if (abort_pulse !== 1'b1) begin bad++; $display("FAIL abort_pulse: got %b want 1", abort_pulse); end
    total++; if (job_valid !== 1'b0) begin bad++; $display("FAIL abort_flush: got %b want 0", job_valid); end
    @(negedge clk);
    total++; if (abort_pulse !== 1'b0) begin bad++; $display("FAIL abort_single: got %b want 0", abort_pulse); end
    csr_read(8'h24, d, v);
    total++; if (d !== 32'h0002_0000) begin bad++; $display("FAIL abort_qstat: got %h want %h", d, 32'h0002_0000); end
    csr_read(8'h28, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL abort_noerr: got %h want %h", d, 32'h0); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d; logic v;
    csr_read(8'h44, d, v);
    total++; if (d !== 32'hDEAD_BEEF || v !== 1'b1) begin bad++; $display("FAIL unmapped: got %h/%b want deadbeef/1", d, v); end
    repeat (2) @(negedge clk);
    total++; if (csr_rdata !== 32'hDEAD_BEEF || csr_rvalid !== 1'b0) begin bad++;
      $display("FAIL rdata_hold: got %h/%b want deadbeef/0", csr_rdata, csr_rvalid); end
`ifdef CSR_PERF_CNT_EN
    csr_write(8'h34, 32'h0);
    @(negedge clk); core_busy = 1'b1;
    repeat (10) @(negedge clk);
    core_busy = 1'b0;
    csr_read(8'h34, d, v);
    total++; if (d !== 32'd10) begin bad++; $display("FAIL perf_busy: got %h want %h", d, 32'd10); end
`else
    csr_read(8'h34, d, v);
    total++; if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL perf_absent: got %h want deadbeef", d); end
`endif
  endtask

  task automatic test_reset_midop();
    logic [31:0] d; logic v;
    csr_write(8'h00, 32'h1);
    total++; if (job_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre: got %b want 1", job_valid); end
    @(negedge clk); rst = 1'b1;
    #1;
    total++; if (job_valid !== 1'b0) begin bad++; $display("FAIL midrst_async: got %b want 0", job_valid); end
    @(negedge clk); rst = 1'b0;
    csr_read(8'h10, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL midrst_tm: got %h want %h", d, 32'h0); end
    csr_read(8'h20, d, v);
    total++; if (d !== 32'h3F80_0000) begin bad++; $display("FAIL midrst_sw: got %h want %h", d, 32'h3F80_0000); end
  endtask

  initial begin
    rst = 1'b1;
    csr_wen = 1'b0; csr_ren = 1'b0; csr_addr = '0; csr_wdata = '0;
    core_busy = 1'b0; core_done_pulse = 1'b0; rx_crc_error = 1'b0; job_ready = 1'b0;
    test_reset();
    test_push_pop();
    test_illegal();
    test_overflow();
    test_irq();
    test_status_misc();
    test_abort();
    test_unmapped();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csr_jobq.md
Name: csr_jobq

Overview:
- Second-generation accelerator control/status block. Host writes a job descriptor into shadow registers, then rings a doorbell that pushes the descriptor into a parametrised job queue.
- Core pops jobs through a valid/ready handshake. Host can therefore queue tiles back-to-back without polling busy.
- Adds maskable interrupt, done counter, queue status and registered read path.
- Sits between the UART/AXI-lite CSR shim and the core FSM.

Parameters:
- ADDR_W, 8, byte-address width; legal range 6..12.
- JOBQ_DEPTH, 4, job queue entries; power of two, 2..16.
- LVL_W, $clog2(JOBQ_DEPTH)+1, queue level width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- csr_wen  in  1  write strobe, one cycle per access
- csr_ren  in  1  read strobe
- csr_addr  in  ADDR_W  byte address, 32-bit aligned
- csr_wdata  in  32  write data
- csr_rdata  out  32  read data, registered
- csr_rvalid  out  1  pulses 1 cycle after csr_ren
- core_busy  in  1  core executing
- core_done_pulse  in  1  job complete
- rx_crc_error  in  1  UART CRC error pulse
- job_valid  out  1  queue head valid
- job_ready  in  1  core accepts head
- job_desc  out  256  {Sw,Sa,Tk,Tn,Tm,K,N,M}, M in [31:0]
- abort_pulse  out  1  single-cycle abort
- irq  out  1  level interrupt, registered

Behaviour:
- Address map:
  - 0x00 CTRL: [0] doorbell (W1P), [1] abort (W1P), [2] irq_en (RW). Reads {29'b0,irq_en,2'b0}.
  - 0x04..0x18 shadow M,N,K,Tm,Tn,Tk (RW). Reset 0.
  - 0x1C Sa, 0x20 Sw (RW). Reset 32'h3F80_0000.
  - 0x24 QSTAT (RO): [LVL_W-1:0] level, [16] full, [17] empty.
  - 0x28 STATUS: [0] busy (RO); [1] done, [8] err_overflow, [9] err_illegal, [10] err_crc, all sticky W1C.
  - 0x2C IRQ_MASK (RW): bits align with STATUS [10:1]; reset 0.
  - 0x30 DONE_CNT (RO): 32-bit count of core_done_pulse, saturating at 32'hFFFF_FFFF. Any write clears it.
  - Unmapped addresses read 32'hDEAD_BEEF; writes to them are ignored.
- Reset values:
  - csr_rdata=0, csr_rvalid=0, job_valid=0, abort_pulse=0, irq=0.
  - Queue empty; all sticky bits 0; DONE_CNT=0.
- Read path: on csr_ren, csr_rdata <= mux(csr_addr) and csr_rvalid <= 1, both next cycle. csr_rdata holds until the next read.
- Doorbell handling:
  - Any of Tm/Tn/Tk == 0: no push; set err_illegal.
  - Queue full: no push; set err_overflow. Exception: pop in the same cycle, in which case the push is accepted and level is unchanged.
  - Otherwise: push the shadow snapshot. The entry is visible at job_valid on the next cycle.
- Queue handshake:
  - First-word fall-through.
  - job_valid = !empty; job_desc = head entry, stable while job_valid && !job_ready.
  - A pop occurs when job_valid && job_ready.
- Abort:
  - abort_pulse=1 the cycle after the write.
  - Queue flushes to empty in that same cycle; a pop in that cycle is discarded.
  - Doorbell and abort in the same write: abort wins, no push, no error.
- Sticky bits:
  - Set on their event, cleared by W1C.
  - Set and clear in the same cycle: set wins.
- DONE_CNT: increments on core_done_pulse. Clear and pulse in the same cycle gives 1.
- irq <= irq_en && |(STATUS[10:1] & IRQ_MASK[10:1]).
- Shadow writes in the same cycle as a doorbell: the push uses the old shadow values.
- Reset asserted mid-operation: queue contents are lost and all state returns to reset values immediately.

Optional Feature:
- CSR_PERF_CNT_EN defined:
  - 0x34 PERF_BUSY: 32-bit count of cycles with core_busy=1.
  - 0x38 PERF_STALL: 32-bit count of cycles with job_valid && !job_ready.
  - Both saturate; any write to either clears both.
- CSR_PERF_CNT_EN undefined: 0x34/0x38 read 32'hDEAD_BEEF and no counter flops exist.

Decomposition:
- Package csr_jobq_pkg holds:
  - address localparams;
  - STATUS/CTRL bit indices;
  - job descriptor field offsets and width (8 x 32);
  - reset constants (1.0f, DEAD_BEEF).
- Sub-module csr_job_fifo, parametrised by DEPTH and WIDTH:
  - FWFT with push/pop/flush inputs;
  - outputs level, full, empty.
- Register decode and the read mux remain in csr_jobq.

Test Plan:
- Write Tm=Tn=Tk=4 and M=16, then CTRL=1 with job_ready=0:
  - job_valid=1 the next cycle; job_desc[127:96]=4; QSTAT level=1.
  - Assert job_ready: level returns to 0.
- Tk=0, then CTRL=1: no push; STATUS[9]=1. Write STATUS=0x200: reads 0.
- Push JOBQ_DEPTH jobs, then a fifth doorbell:
  - err_overflow=1, full=1.
  - Repeat with job_ready=1 on the fifth doorbell cycle: accepted, no error.
- IRQ_MASK=0x2, irq_en=1, pulse core_done_pulse:
  - irq=1 within 2 cycles; DONE_CNT=1.
  - W1C STATUS bit 1: irq deasserts.
- Queue holds 3 jobs, write CTRL=0x3:
  - abort_pulse for one cycle; empty=1; level=0; no push.
- Read 0x44 (unmapped): csr_rvalid the next cycle with rdata=DEAD_BEEF.
  - With CSR_PERF_CNT_EN: 10 busy cycles give PERF_BUSY=10.
